acum_loader: RTL
================

# acum_loader

Sequencer that drives the operand/select inputs of the adder-plus-accumulator datapath so that the 6-bit accumulator ends at a requested target value. It accepts a target over a valid/ready handshake, pulses a clear to the accumulator, then issues a stream of operand beats (two 3-bit operands plus a 2-bit select) whose increments sum exactly to the target. It sits upstream of the datapath top level, on the driving side of its `i_data1`/`i_data2`/`i_sel` interface.

## Interface
- `NB_TARGET`, 6: target/accumulator width.
- `NB_OPER`, 3: operand width; maximum increment per beat is `2*(2^NB_OPER-1)` (14).
- `NB_BEATS`, 3: beat-counter width; must hold `ceil((2^NB_TARGET-1)/14)` (5).
- `clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_target`  in  NB_TARGET  requested final accumulator value, 0..63.
- `i_valid`  in  1  target request valid.
- `o_ready`  out  1  block idle and able to accept a target.
- `o_data1`  out  NB_OPER  operand 1 for the current beat.
- `o_data2`  out  NB_OPER  operand 2 for the current beat.
- `o_sel`  out  2  select encoding: 00 pass data1, 01 pass data2, 10 data1+data2, 11 zero.
- `o_valid`  out  1  current beat valid.
- `i_ready`  in  1  downstream accepts the beat this cycle.
- `o_clear`  out  1  one-cycle clear pulse to the accumulator.
- `o_done`  out  1  one-cycle pulse after the last beat is accepted.
- `o_beats`  out  NB_BEATS  beats accepted for the current/most recent target.

## Operation
- States: IDLE, CLEAR, ISSUE, DONE. Registered state, remainder `rem` (NB_TARGET bits), beat counter.
- IDLE: `o_ready=1`. On `i_valid & o_ready`: `rem <= i_target`, `o_beats <= 0`, go to CLEAR.
- CLEAR: `o_clear=1` for exactly one cycle (not handshaked). Next: ISSUE if `rem != 0`, else DONE.
- ISSUE: `o_valid=1`; operands decoded from `rem` only:
  - `rem >= 14`: data1=7, data2=7, sel=10 (increment 14).
  - `8 <= rem <= 13`: data1=7, data2=rem-7, sel=10.
  - `1 <= rem <= 7`: data1=rem, data2=0, sel=00.
- On `o_valid & i_ready`: `rem <= rem - increment`, `o_beats <= o_beats+1`; if new `rem == 0`, go to DONE, else stay in ISSUE.
- DONE: `o_done=1` for one cycle, then IDLE.
- When `o_valid=0`: `o_data1=0`, `o_data2=0`, `o_sel=11`, so the datapath adds nothing.
- Beat count for target T is `ceil(T/14)`: 0 for T=0, 5 for T=63. The sum of increments never exceeds T, so the accumulator never overflows.
- `i_valid` outside IDLE is ignored (`o_ready=0`). The target is not re-sampled.

## Timing
- Reset (async, immediate): state IDLE, `rem=0`, `o_beats=0`, `o_ready=1`, `o_valid=0`, `o_clear=0`, `o_done=0`, `o_data1=0`, `o_data2=0`, `o_sel=11`.
- Outputs are decoded from registers only; there are no combinational input-to-output paths.
- With the target accepted at edge 0 and `i_ready` held high: `o_clear` is high in cycle 1, beats occupy cycles 2..N+1, `o_done` is high in cycle N+2, and `o_ready` returns in cycle N+3. For T=0, `o_done` is high in cycle 2.
- Backpressure: while `o_valid & !i_ready`, `o_data1`, `o_data2`, `o_sel` and `rem` hold stable. There is no limit on stall length.
- Reset mid-operation aborts immediately: no `o_done`, and partial beats are discarded.
- `o_beats` holds its final value until the next accept.

## Test plan
- Target 0 -> `o_clear` pulse in cycle 1, no `o_valid`, `o_done` in cycle 2, `o_beats=0`.
- Target 23, `i_ready=1` -> beats (7,7,10) then (7,2,10); `o_done` in cycle 4; `o_beats=2`; accumulator model reads 23.
- Target 63 -> four beats of (7,7,10) then (7,0,00); `o_beats=5`; accumulator reads 63 with no overflow.
- Target 8, `i_ready` low for 3 cycles on the first beat -> (7,1,10) held stable for 4 cycles, accepted once; `o_beats=1`, accumulator reads 8.
- Target 40, `i_rst` asserted after the second beat -> all outputs at reset values immediately, no `o_done`; a new target of 5 afterwards -> single beat (5,0,00).
- Target 20 accepted, then `i_valid` pulsed with target 9 during ISSUE -> ignored, `o_ready=0`; final accumulator reads 20, `o_beats=2`.

Source files
------------

// File: rtl/acum_loader.sv
// Sequencer that loads a target value into the adder-plus-accumulator datapath:
// clear pulse, then operand beats whose increments sum exactly to the target.
module acum_loader #(
  parameter int NB_TARGET = 6,
  parameter int NB_OPER   = 3,
  parameter int NB_BEATS  = 3
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic [NB_TARGET-1:0] i_target,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [NB_OPER-1:0]   o_data1,
  output logic [NB_OPER-1:0]   o_data2,
  output logic [1:0]           o_sel,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_clear,
  output logic                 o_done,
  output logic [NB_BEATS-1:0]  o_beats
);

  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, DONE} state_t;
  typedef enum logic [1:0] {
    SEL_D1   = 2'b00,
    SEL_D2   = 2'b01,
    SEL_ADD  = 2'b10,
    SEL_ZERO = 2'b11
  } sel_t;

  localparam logic [NB_OPER-1:0]   OPER_MAX_N = NB_OPER'((1 << NB_OPER) - 1);
  localparam logic [NB_TARGET-1:0] OPER_MAX   = NB_TARGET'((1 << NB_OPER) - 1);
  localparam logic [NB_TARGET-1:0] INC_MAX    = NB_TARGET'(2 * ((1 << NB_OPER) - 1));

  state_t                state_q, state_d;
  logic [NB_TARGET-1:0]  rem_q, rem_d;
  logic [NB_BEATS-1:0]   beats_q, beats_d;
  logic [NB_OPER-1:0]    op1, op2;
  sel_t                  op_sel;
  logic [NB_TARGET-1:0]  inc;

  // Beat operands depend on the registered remainder only, so they hold
  // steady for as long as the downstream stalls.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    op1    = '0;
    op2    = '0;
    op_sel = SEL_ZERO;
    inc    = '0;
    if (rem_q >= INC_MAX) begin
      op1    = OPER_MAX_N;
      op2    = OPER_MAX_N;
      op_sel = SEL_ADD;
      inc    = INC_MAX;
    end else if (rem_q > OPER_MAX) begin
      op1    = OPER_MAX_N;
      op2    = NB_OPER'(rem_q - OPER_MAX);
      op_sel = SEL_ADD;
      inc    = rem_q;
    end else if (rem_q != '0) begin
      op1    = NB_OPER'(rem_q);
      op_sel = SEL_D1;
      inc    = rem_q;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          rem_d   = i_target;
          beats_d = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = (rem_q != '0) ? ISSUE : DONE;
      ISSUE: begin
        if (i_ready) begin
          rem_d   = rem_q - inc;
          beats_d = beats_q + NB_BEATS'(1);
          if (rem_d == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
    end
  end

  // Outside ISSUE the datapath sees operands of zero with the zero select.
  assign o_ready = (state_q == IDLE);
  assign o_clear = (state_q == CLEAR);
  assign o_valid = (state_q == ISSUE);
  assign o_done  = (state_q == DONE);
  assign o_data1 = o_valid ? op1 : '0;
  assign o_data2 = o_valid ? op2 : '0;
  assign o_sel   = o_valid ? op_sel : SEL_ZERO;
  assign o_beats = beats_q;

endmodule
